pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-generation program counter. It generates the fetch address, applies a valid/ready handshake toward instruction fetch, and evaluates branch conditions against ALU flags. It supports 2- and 4-byte instructions and keeps a parametrised return address stack (RAS) for call/return. It sits between decode/execute (redirect sources) and the instruction-fetch port.

Parameters:
INSTR_ADDR_WIDTH, 32, width of all instruction addresses
RESET_VECTOR, 0, fetch address after reset (must be even)
RAS_DEPTH, 8, return address stack entries (power of two, >=2)
FLAG_WIDTH, 4, flag vector {N,Z,C,V}, MSB first

Ports:
clk  in  1  clock
sync_rst_n  in  1  synchronous active-low reset
clk_en  in  1  global clock enable; all state holds when 0
stall  in  1  pipeline stall; PC and RAS hold
fetch_ready  in  1  fetch port accepts fetch_addr this cycle
fetch_valid  out  1  fetch_addr is valid
fetch_addr  out  INSTR_ADDR_WIDTH  current PC
instr_len  in  1  length of instruction at PC: 0 = 2 bytes, 1 = 4 bytes
branch_en  in  1  conditional register-relative branch
jump_en  in  1  unconditional PC-relative jump
call_en  in  1  qualifier: push link address when the redirect is taken
ret_en  in  1  return: pop RAS
branch_cond  in  5  condition code (pc_seq_pkg::cond_e)
flags  in  FLAG_WIDTH  {N,Z,C,V}
branch_base_addr  in  INSTR_ADDR_WIDTH  base register value; also the return target on RAS underflow
short_offset  in  INSTR_ADDR_WIDTH  sign-extended 16-bit halfword offset
long_offset  in  INSTR_ADDR_WIDTH  sign-extended 24-bit halfword offset
link_addr  out  INSTR_ADDR_WIDTH  PC + instr length (combinational)
taken  out  1  registered; redirect applied last advance
ras_empty  out  1  RAS holds no entries
ras_overflow  out  1  sticky; an entry was overwritten
ras_underflow  out  1  registered one-cycle pulse; ret on empty RAS

Behaviour:
- Reset (sync_rst_n=0 at posedge, regardless of clk_en):
  - PC=RESET_VECTOR, fetch_valid=0, taken=0.
  - RAS pointer and count cleared: ras_empty=1, ras_overflow=0, ras_underflow=0.
  - fetch_valid=1 from the first cycle after reset release.
- fetch_addr = PC register; no combinational path from redirect inputs to fetch_addr.
- Update enable upd = clk_en & !stall.
- Target priority when upd=1:
  - ret_en: PC = RAS top; on empty RAS, PC = branch_base_addr and ras_underflow pulses.
  - else branch_en & cond_true: PC = branch_base_addr + (short_offset<<1).
  - else jump_en: PC = PC + (long_offset<<1).
  - else if fetch_ready: PC = PC + (instr_len ? 4 : 2).
  - else hold.
- Redirects do not wait for fetch_ready; an unaccepted fetch is discarded.
- All sums are modulo 2^INSTR_ADDR_WIDTH; bit 0 of every target is forced to 0.
- taken <= 1 for a ret, taken branch, or jump; 0 for a sequential advance or not-taken branch. Holds when upd=0.
- Conditions (cond_e):
  - 0 AL, 1 NV, 2 EQ Z, 3 NE !Z, 4 CS C, 5 CC !C, 6 MI N, 7 PL !N, 8 VS V, 9 VC !V.
  - 10 HI C&!Z, 11 LS !C|Z, 12 GE N==V, 13 LT N!=V, 14 GT !Z&(N==V), 15 LE Z|(N!=V).
  - 16-31 reserved: false.
- RAS:
  - Push link_addr when upd & call_en & (jump_en | (branch_en & cond_true)) & !ret_en.
  - Pop on upd & ret_en & !empty.
  - ret_en & call_en together: top entry is replaced by link_addr (tail call); count unchanged; PC goes to the old top.
  - Push when full: circular overwrite of the oldest entry, count stays RAS_DEPTH, ras_overflow set until reset.
  - Pop on empty: pointer and count unchanged.
- stall or clk_en=0: all registers hold, including sticky flags. ras_underflow clears on the next upd cycle.
- Reset mid-redirect: reset wins, and RAS contents are invalidated.

Decomposition:
- Package pc_seq_pkg holds:
  - cond_e enum (5-bit)
  - INSTR_LEN_2B/INSTR_LEN_4B constants
  - flag bit indices FLAG_N/Z/C/V
  - cond_eval function (cond_e, flags) -> bit
- Sub-module pc_ras, the return address stack:
  - parameters: width, depth
  - inputs: push, pop, replace, wdata
  - outputs: top, empty, overflow
- pc_sequencer holds the PC register, target mux, and handshake.

Test Plan:
- Reset, then fetch_ready=1 with instr_len alternating 0/1 -> fetch_addr 0x0, 0x2, 0x6, 0x8, 0xC; fetch_valid=0 during reset, 1 after.
- PC=0x100, branch_en, cond=EQ, flags Z=1, base=0x2000, short_offset=-4 -> PC=0x1FF8, taken=1. Same with Z=0 and instr_len=1 -> PC=0x104, taken=0.
- PC=0x40, jump_en+call_en, long_offset=0x10, instr_len=1 -> PC=0x60, RAS top=0x44. Then ret_en -> PC=0x44, ras_empty=1.
- RAS_DEPTH=4: 5 calls pushing 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_overflow=1. Pops return 0x50, 0x40, 0x30, 0x20. A 5th ret -> PC=branch_base_addr, ras_underflow pulse.
- stall=1 or clk_en=0 with jump_en asserted -> PC, RAS and taken unchanged. fetch_ready=0 with no redirect -> PC held.
- PC=0xFFFFFFFE, sequential +2 -> PC=0x0. Reset asserted in the same cycle as ret_en -> PC=RESET_VECTOR, ras_empty=1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: condition codes, instruction
// length encoding, flag bit positions and the condition evaluator.
package pc_seq_pkg;

  typedef enum logic [4:0] {
    COND_AL = 5'd0,
    COND_NV = 5'd1,
    COND_EQ = 5'd2,
    COND_NE = 5'd3,
    COND_CS = 5'd4,
    COND_CC = 5'd5,
    COND_MI = 5'd6,
    COND_PL = 5'd7,
    COND_VS = 5'd8,
    COND_VC = 5'd9,
    COND_HI = 5'd10,
    COND_LS = 5'd11,
    COND_GE = 5'd12,
    COND_LT = 5'd13,
    COND_GT = 5'd14,
    COND_LE = 5'd15
  } cond_e;

  localparam logic INSTR_LEN_2B = 1'b0;
  localparam logic INSTR_LEN_4B = 1'b1;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Codes 16-31 are reserved and never true.
  function automatic logic cond_eval(
    input cond_e      c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cy = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      COND_AL: cond_eval = 1'b1;
      COND_NV: cond_eval = 1'b0;
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = !z;
      COND_CS: cond_eval = cy;
      COND_CC: cond_eval = !cy;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = !n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = !v;
      COND_HI: cond_eval = cy & !z;
      COND_LS: cond_eval = !cy | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = !z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack; pushes on a full stack overwrite
// the oldest entry. Ports: push/pop/replace, wdata -> top/empty/overflow.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    top_idx;
  logic [AW:0]      cnt;
  logic             full;
  logic             we;
  logic [AW-1:0]    widx;

  assign top_idx = ptr - AW'(1);
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));

  assign we   = sync_rst_n & (push | (replace & !empty));
  assign widx = push ? ptr : top_idx;

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Reset clears the count, which invalidates all stored entries.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (full) overflow <= 1'b1;
      else      cnt      <= cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= top_idx;
      cnt <= cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with fetch handshake, branch/jump/return redirect
// and RAS. fetch_addr is the PC register; link_addr = PC + length.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 8,
  parameter int FLAG_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        sync_rst_n,
  input  logic                        clk_en,
  input  logic                        stall,
  input  logic                        fetch_ready,
  output logic                        fetch_valid,
  output logic [INSTR_ADDR_WIDTH-1:0] fetch_addr,
  input  logic                        instr_len,
  input  logic                        branch_en,
  input  logic                        jump_en,
  input  logic                        call_en,
  input  logic                        ret_en,
  input  logic [4:0]                  branch_cond,
  input  logic [FLAG_WIDTH-1:0]       flags,
  input  logic [INSTR_ADDR_WIDTH-1:0] branch_base_addr,
  input  logic [INSTR_ADDR_WIDTH-1:0] short_offset,
  input  logic [INSTR_ADDR_WIDTH-1:0] long_offset,
  output logic [INSTR_ADDR_WIDTH-1:0] link_addr,
  output logic                        taken,
  output logic                        ras_empty,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  localparam int W = INSTR_ADDR_WIDTH;

  logic [W-1:0] pc_q;
  logic [W-1:0] next_pc;
  logic [W-1:0] ras_top;
  logic         valid_q;
  logic         taken_q;
  logic         unf_q;
  logic         upd;
  logic         cond_true;
  logic         br_take;
  logic         redir;
  logic         push;
  logic         pop;
  logic         replace;

  assign upd       = clk_en & !stall;
  assign cond_true = cond_eval(cond_e'(branch_cond), flags[3:0]);
  assign br_take   = branch_en & cond_true;
  assign link_addr = pc_q + (instr_len == INSTR_LEN_4B ? W'(4) : W'(2));

  assign fetch_addr    = pc_q;
  assign fetch_valid   = valid_q;
  assign taken         = taken_q;
  assign ras_underflow = unf_q;

  assign push    = upd & call_en & (jump_en | br_take) & !ret_en;
  assign pop     = upd & ret_en & !call_en;
  assign replace = upd & ret_en & call_en;

  // Redirects ignore fetch_ready; a sequential step needs an
  // accepted fetch so the first post-reset address is not skipped.
  always_comb begin
    next_pc = pc_q;
    redir   = 1'b0;
    if (ret_en) begin
      redir   = 1'b1;
      next_pc = ras_empty ? branch_base_addr : ras_top;
    end else if (br_take) begin
      redir   = 1'b1;
      next_pc = branch_base_addr + (short_offset << 1);
    end else if (jump_en) begin
      redir   = 1'b1;
      next_pc = pc_q + (long_offset << 1);
    end else if (valid_q && fetch_ready) begin
      next_pc = link_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (upd) begin
        pc_q    <= {next_pc[W-1:1], 1'b0};
        taken_q <= redir;
        unf_q   <= ret_en & ras_empty;
      end
    end
  end

  pc_ras #(
    .WIDTH(W),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .sync_rst_n(sync_rst_n),
    .push      (push),
    .pop       (pop),
    .replace   (replace),
    .wdata     (link_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_overflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 4-entry RAS.
// Checks sequential fetch, branches, calls/returns, holds and reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        sync_rst_n;
  logic        clk_en;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        instr_len;
  logic        branch_en;
  logic        jump_en;
  logic        call_en;
  logic        ret_en;
  logic [4:0]  branch_cond;
  logic [3:0]  flags;
  logic [31:0] branch_base_addr;
  logic [31:0] short_offset;
  logic [31:0] long_offset;
  logic [31:0] link_addr;
  logic        taken;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ras_underflow;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(
    .INSTR_ADDR_WIDTH(32),
    .RESET_VECTOR    (32'h0),
    .RAS_DEPTH       (4),
    .FLAG_WIDTH      (4)
  ) dut (
    .clk             (clk),
    .sync_rst_n      (sync_rst_n),
    .clk_en          (clk_en),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .fetch_addr      (fetch_addr),
    .instr_len       (instr_len),
    .branch_en       (branch_en),
    .jump_en         (jump_en),
    .call_en         (call_en),
    .ret_en          (ret_en),
    .branch_cond     (branch_cond),
    .flags           (flags),
    .branch_base_addr(branch_base_addr),
    .short_offset    (short_offset),
    .long_offset     (long_offset),
    .link_addr       (link_addr),
    .taken           (taken),
    .ras_empty       (ras_empty),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch_en    = 1'b0;
    jump_en      = 1'b0;
    call_en      = 1'b0;
    ret_en       = 1'b0;
    branch_cond  = 5'd0;
    short_offset = '0;
    long_offset  = '0;
  endtask

  // Branch-always with zero offset lands the PC on addr.
  task automatic goto(input logic [31:0] addr);
    idle();
    branch_en        = 1'b1;
    branch_cond      = 5'd0;
    branch_base_addr = addr;
    step();
    idle();
  endtask

  initial begin
    sync_rst_n       = 1'b0;
    clk_en           = 1'b1;
    stall            = 1'b0;
    fetch_ready      = 1'b0;
    instr_len        = 1'b0;
    flags            = 4'b0000;
    branch_base_addr = '0;
    idle();
    step();
    step();
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_pc", fetch_addr, 32'h0);
    chk("rst_taken", 32'(taken), 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_ovf", 32'(ras_overflow), 32'h0);
    chk("rst_unf", 32'(ras_underflow), 32'h0);

    sync_rst_n  = 1'b1;
    fetch_ready = 1'b1;
    step();
    chk("first_valid", 32'(fetch_valid), 32'h1);
    chk("seq0", fetch_addr, 32'h0);
    instr_len = 1'b0;
    step();
    chk("seq1", fetch_addr, 32'h2);
    instr_len = 1'b1;
    step();
    chk("seq2", fetch_addr, 32'h6);
    instr_len = 1'b0;
    step();
    chk("seq3", fetch_addr, 32'h8);
    instr_len = 1'b1;
    step();
    chk("seq4", fetch_addr, 32'hC);

    goto(32'h100);
    chk("goto100", fetch_addr, 32'h100);
    branch_en        = 1'b1;
    branch_cond      = 5'd2;
    flags            = 4'b0100;
    branch_base_addr = 32'h2000;
    short_offset     = 32'hFFFF_FFFC;
    step();
    chk("beq_pc", fetch_addr, 32'h1FF8);
    chk("beq_taken", 32'(taken), 32'h1);

    goto(32'h100);
    branch_en        = 1'b1;
    branch_cond      = 5'd2;
    flags            = 4'b0000;
    branch_base_addr = 32'h2000;
    short_offset     = 32'hFFFF_FFFC;
    instr_len        = 1'b1;
    step();
    chk("bne_pc", fetch_addr, 32'h104);
    chk("bne_taken", 32'(taken), 32'h0);

    goto(32'h40);
    idle();
    jump_en     = 1'b1;
    call_en     = 1'b1;
    long_offset = 32'h10;
    instr_len   = 1'b1;
    #1;
    chk("link", link_addr, 32'h44);
    step();
    chk("call_pc", fetch_addr, 32'h60);
    chk("call_nonempty", 32'(ras_empty), 32'h0);
    chk("call_taken", 32'(taken), 32'h1);
    idle();
    ret_en = 1'b1;
    step();
    chk("ret_pc", fetch_addr, 32'h44);
    chk("ret_empty", 32'(ras_empty), 32'h1);
    chk("ret_taken", 32'(taken), 32'h1);

    instr_len = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      goto(32'(k * 16 - 2));
      branch_en        = 1'b1;
      branch_cond      = 5'd0;
      call_en          = 1'b1;
      branch_base_addr = 32'h300;
      step();
      idle();
      if (k == 4) chk("ovf_at4", 32'(ras_overflow), 32'h0);
    end
    chk("ovf_at5", 32'(ras_overflow), 32'h1);

    ret_en           = 1'b1;
    branch_base_addr = 32'h500;
    step();
    chk("pop1", fetch_addr, 32'h50);
    step();
    chk("pop2", fetch_addr, 32'h40);
    step();
    chk("pop3", fetch_addr, 32'h30);
    step();
    chk("pop4", fetch_addr, 32'h20);
    chk("pop4_empty", 32'(ras_empty), 32'h1);
    chk("pop4_unf", 32'(ras_underflow), 32'h0);
    step();
    chk("unf_pc", fetch_addr, 32'h500);
    chk("unf_pulse", 32'(ras_underflow), 32'h1);
    idle();
    instr_len = 1'b0;
    step();
    chk("unf_clear", 32'(ras_underflow), 32'h0);
    chk("ovf_sticky", 32'(ras_overflow), 32'h1);
    chk("seq_after", fetch_addr, 32'h502);
    chk("seq_taken0", 32'(taken), 32'h0);

    jump_en     = 1'b1;
    call_en     = 1'b1;
    long_offset = 32'h100;
    stall       = 1'b1;
    step();
    chk("stall_pc", fetch_addr, 32'h502);
    chk("stall_taken", 32'(taken), 32'h0);
    chk("stall_ras", 32'(ras_empty), 32'h1);
    stall  = 1'b0;
    clk_en = 1'b0;
    step();
    chk("cen_pc", fetch_addr, 32'h502);
    chk("cen_taken", 32'(taken), 32'h0);
    chk("cen_ras", 32'(ras_empty), 32'h1);
    clk_en = 1'b1;
    idle();
    fetch_ready = 1'b0;
    step();
    chk("nordy_pc", fetch_addr, 32'h502);
    fetch_ready = 1'b1;

    goto(32'hFFFF_FFFE);
    chk("wrap_pre", fetch_addr, 32'hFFFF_FFFE);
    instr_len = 1'b0;
    step();
    chk("wrap_pc", fetch_addr, 32'h0);

    jump_en     = 1'b1;
    call_en     = 1'b1;
    long_offset = 32'h8;
    step();
    chk("pre_rst_pc", fetch_addr, 32'h10);
    chk("pre_rst_ras", 32'(ras_empty), 32'h0);
    idle();
    ret_en     = 1'b1;
    sync_rst_n = 1'b0;
    step();
    chk("rr_pc", fetch_addr, 32'h0);
    chk("rr_empty", 32'(ras_empty), 32'h1);
    chk("rr_valid", 32'(fetch_valid), 32'h0);
    chk("rr_ovf", 32'(ras_overflow), 32'h0);
    chk("rr_taken", 32'(taken), 32'h0);
    idle();
    sync_rst_n = 1'b1;
    step();
    chk("rr_valid1", 32'(fetch_valid), 32'h1);
    chk("rr_pc1", fetch_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
